// File: rtl/banked_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : banked_regfile_sb
//  Purpose  : Parametrised register file with two registered read ports, one
//             write port and a per-register busy scoreboard.
//             The scoreboard bit is set when a destination issues and
//             cleared when that register is written back, so decode can
//             detect RAW hazards.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    register / data port width
//    ADDR_W    register index width (NUM_REGS = 2**ADDR_W, derived)
//  Ports
//    clk, rst                  clock, asynchronous active-low reset
//    rd_en, rd_addr1/2         read strobe and indices (both ports sample)
//    rd_data1/2, rd_busy1/2    registered read data / busy bit
//    wr_en, wr_addr, wr_data   writeback port (clears busy)
//    iss_en, iss_addr          issue port (sets busy)
//    iss_err                   one-cycle pulse: issue hit a busy register
//    busy_vec                  scoreboard flops, bit i = register i busy
//  Build option
//    BANKED_REGFILE_BYPASS_EN  when defined, a read and a write to the same
//                              register on the same edge forwards the write
//                              data and the post-write busy bit.
// ============================================================================
module banked_regfile_sb #(
  parameter  int DATA_W   = 16,
  parameter  int ADDR_W   = 4,
  localparam int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic                iss_err,
  output logic [NUM_REGS-1:0] busy_vec
);

`ifdef BANKED_REGFILE_BYPASS_EN
  localparam bit C_BYPASS_EN = 1'b1;
`else
  localparam bit C_BYPASS_EN = 1'b0;
`endif

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic                r_iss_err;
  logic                w_iss_err_next;
  logic [DATA_W-1:0]   r_rd_data1, r_rd_data2;
  logic                r_rd_busy1, r_rd_busy2;
  logic [DATA_W-1:0]   w_rd_data1, w_rd_data2;
  logic                w_rd_busy1, w_rd_busy2;
  logic                w_fwd1, w_fwd2;

  // Scoreboard next state: write clears, issue sets; set has priority so a
  // freshly issued producer is never lost to an older writeback.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    assign w_busy_next[gi] =
        (r_busy[gi] & ~(wr_en & (wr_addr == ADDR_W'(gi)))) |
        (iss_en & (iss_addr == ADDR_W'(gi)));
  end

  // A same-cycle writeback to the issued register retires the old producer,
  // so that issue is not a hazard.
  assign w_iss_err_next = iss_en & r_busy[iss_addr] &
                          ~(wr_en & (wr_addr == iss_addr));

  // Forwarding selects the post-write view only when the write hits the
  // addressed register; otherwise the pre-edge state is returned.
  assign w_fwd1 = C_BYPASS_EN & wr_en & (wr_addr == rd_addr1);
  assign w_fwd2 = C_BYPASS_EN & wr_en & (wr_addr == rd_addr2);

  always_comb begin
    w_rd_data1 = r_mem[rd_addr1];
    w_rd_busy1 = r_busy[rd_addr1];
    w_rd_data2 = r_mem[rd_addr2];
    w_rd_busy2 = r_busy[rd_addr2];
    if (w_fwd1) begin
      w_rd_data1 = wr_data;
      w_rd_busy1 = w_busy_next[rd_addr1];
    end
    if (w_fwd2) begin
      w_rd_data2 = wr_data;
      w_rd_busy2 = w_busy_next[rd_addr2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_iss_err  <= 1'b0;
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
      r_rd_busy1 <= 1'b0;
      r_rd_busy2 <= 1'b0;
    end else begin
      r_busy    <= w_busy_next;
      r_iss_err <= w_iss_err_next;
      if (rd_en) begin
        r_rd_data1 <= w_rd_data1;
        r_rd_data2 <= w_rd_data2;
        r_rd_busy1 <= w_rd_busy1;
        r_rd_busy2 <= w_rd_busy2;
      end
    end
  end

  assign rd_data1 = r_rd_data1;
  assign rd_data2 = r_rd_data2;
  assign rd_busy1 = r_rd_busy1;
  assign rd_busy2 = r_rd_busy2;
  assign iss_err  = r_iss_err;
  assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_banked_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_banked_regfile_sb
//  Purpose  : Self-checking bench for banked_regfile_sb. A 16x16 instance is
//             driven with directed and random traffic and compared every
//             cycle against a behavioural model; a 32x32 instance checks the
//             wide configuration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_banked_regfile_sb;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_busy1, rd_busy2;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic          iss_err;
  logic [NR-1:0] busy_vec;

  // wide instance
  logic          p_rd_en = 1'b0;
  logic [4:0]    p_rd_addr1 = '0, p_rd_addr2 = '0;
  logic [31:0]   p_rd_data1, p_rd_data2;
  logic          p_rd_busy1, p_rd_busy2;
  logic          p_wr_en = 1'b0;
  logic [4:0]    p_wr_addr = '0;
  logic [31:0]   p_wr_data = '0;
  logic          p_iss_en = 1'b0;
  logic [4:0]    p_iss_addr = '0;
  logic          p_iss_err;
  logic [31:0]   p_busy_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  banked_regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_err(iss_err), .busy_vec(busy_vec)
  );

  banked_regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut_wide (
    .clk(clk), .rst(rst),
    .rd_en(p_rd_en), .rd_addr1(p_rd_addr1), .rd_addr2(p_rd_addr2),
    .rd_data1(p_rd_data1), .rd_data2(p_rd_data2),
    .rd_busy1(p_rd_busy1), .rd_busy2(p_rd_busy2),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .iss_en(p_iss_en), .iss_addr(p_iss_addr),
    .iss_err(p_iss_err), .busy_vec(p_busy_vec)
  );

  // ---------------- reference model ----------------
`ifdef BANKED_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DW-1:0] m_mem [NR];
  bit            m_busy [NR];
  logic [DW-1:0] e_d1, e_d2;
  bit            e_b1, e_b2, e_err;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    e_d1 = '0; e_d2 = '0; e_b1 = 0; e_b2 = 0; e_err = 0;
  endtask

  // What a read on one port returns, given the pre-edge state and this
  // edge's write/issue.
  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output bit b);
    if (BYPASS && wr_en && wr_addr == a) begin
      d = wr_data;
      b = iss_en && iss_addr == a;
    end else begin
      d = m_mem[a];
      b = m_busy[a];
    end
  endtask

  task automatic model_edge();
    if (rd_en) begin
      model_read(rd_addr1, e_d1, e_b1);
      model_read(rd_addr2, e_d2, e_b2);
    end
    e_err = iss_en && m_busy[iss_addr] && !(wr_en && wr_addr == iss_addr);
    if (wr_en) begin
      m_mem[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (iss_en) m_busy[iss_addr] = 1'b1;
  endtask

  function automatic logic [NR-1:0] model_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic compare_all();
    check_eq("rd_data1", rd_data1, e_d1);
    check_eq("rd_data2", rd_data2, e_d2);
    check_eq("rd_busy1", rd_busy1, e_b1);
    check_eq("rd_busy2", rd_busy2, e_b2);
    check_eq("iss_err",  iss_err,  e_err);
    check_eq("busy_vec", busy_vec, model_busy_vec());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit re, input int a1, input int a2,
                     input bit we, input int wa, input logic [DW-1:0] wd,
                     input bit ie, input int ia);
    rd_en = re; rd_addr1 = AW'(a1); rd_addr2 = AW'(a2);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    iss_en = ie; iss_addr = AW'(ia);
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR-1))
                                       : int'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // mid-run asynchronous reset
    cyc(0, 0, 0, 1, 3, 16'hBEEF, 0, 0);
    cyc(1, 3, 3, 0, 0, '0, 1, 5);
    check_eq("pre_rst_r3", rd_data1, 16'hBEEF);
    check_eq("pre_rst_busy5", busy_vec[5], 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_busy_vec", busy_vec, 16'h0000);
    check_eq("rst_rd_data1", rd_data1, 16'h0000);
    check_eq("rst_rd_data2", rd_data2, 16'h0000);
    rd_en = 0; wr_en = 0; iss_en = 0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 3, 3, 0, 0, '0, 0, 0);
    check_eq("post_rst_r3", rd_data1, 16'h0000);

    // write then read, both ports same register
    cyc(0, 0, 0, 1, 7, 16'h1234, 0, 0);
    cyc(1, 7, 7, 0, 0, '0, 0, 0);
    check_eq("r7_p1", rd_data1, 16'h1234);
    check_eq("r7_p2", rd_data2, 16'h1234);

    // scoreboard lifecycle
    cyc(0, 0, 0, 0, 0, '0, 1, 4);
    check_eq("busy4_set", busy_vec[4], 1'b1);
    cyc(1, 4, 7, 0, 0, '0, 0, 0);
    check_eq("rd_busy_r4", rd_busy1, 1'b1);
    cyc(0, 0, 0, 1, 4, 16'h00AA, 0, 0);
    check_eq("busy4_clr", busy_vec[4], 1'b0);
    cyc(1, 4, 4, 0, 0, '0, 0, 0);
    check_eq("r4_val", rd_data1, 16'h00AA);

    // simultaneous issue + write, then a real issue error
    cyc(0, 0, 0, 0, 0, '0, 1, 2);
    cyc(0, 0, 0, 1, 2, 16'h5555, 1, 2);
    check_eq("busy2_kept", busy_vec[2], 1'b1);
    check_eq("no_err_clr", iss_err, 1'b0);
    cyc(0, 0, 0, 0, 0, '0, 1, 2);
    check_eq("err_pulse", iss_err, 1'b1);
    idle();
    check_eq("err_gone", iss_err, 1'b0);

    // same-edge write/read on a busy register
    cyc(0, 0, 0, 1, 9, 16'h0001, 0, 0);
    cyc(0, 0, 0, 0, 0, '0, 1, 9);
    cyc(1, 9, 9, 1, 9, 16'hFFFF, 0, 0);
    check_eq("byp_data", rd_data1, BYPASS ? 16'hFFFF : 16'h0001);
    check_eq("byp_busy", rd_busy1, BYPASS ? 1'b0 : 1'b1);
    cyc(1, 9, 9, 0, 0, '0, 0, 0);
    check_eq("byp_after", rd_data1, 16'hFFFF);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 1) == 1, rnd_addr(), rnd_addr(),
          $urandom_range(0, 4) < 2, rnd_addr(), DW'($urandom),
          $urandom_range(0, 4) < 2, rnd_addr());
    end
    idle();

    // wide configuration
    p_wr_en = 1; p_wr_addr = 5'd31; p_wr_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    p_wr_addr = 5'd0; p_wr_data = 32'h1;
    @(posedge clk); #1;
    p_wr_en = 0;
    p_rd_en = 1; p_rd_addr1 = 5'd31; p_rd_addr2 = 5'd0;
    p_iss_en = 1; p_iss_addr = 5'd31;
    @(posedge clk); #1;
    p_rd_en = 0; p_iss_en = 0;
    check_eq("w_r31", p_rd_data1, 32'hDEADBEEF);
    check_eq("w_r0", p_rd_data2, 32'h1);
    check_eq("w_busy_vec", p_busy_vec, 32'h8000_0000);
    p_rd_en = 1;
    @(posedge clk); #1;
    p_rd_en = 0;
    check_eq("w_rd_busy31", p_rd_busy1, 1'b1);
    check_eq("w_rd_busy0", p_rd_busy2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/banked_regfile_sb.md
Name: banked_regfile_sb

Overview:
- Parametrised successor to the CPU's 16x16 register file.
- Configurable data width and register count, two registered (synchronous) read ports, one write port.
- Per-register busy scoreboard: set at issue, cleared at writeback, so decode can detect RAW hazards.
- Sits between decode (read/issue) and writeback (write) in the pipeline.

Parameters:
- DATA_W, 16, width of each register and of all data ports.
- ADDR_W, 4, register index width; register count NUM_REGS = 2**ADDR_W (derived, not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_en  input  1  read strobe; both read ports sample on this edge.
- rd_addr1  input  ADDR_W  read port 1 index.
- rd_addr2  input  ADDR_W  read port 2 index.
- rd_data1  output  DATA_W  registered read data, port 1.
- rd_data2  output  DATA_W  registered read data, port 2.
- rd_busy1  output  1  registered busy bit of the register read on port 1.
- rd_busy2  output  1  registered busy bit of the register read on port 2.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write index.
- wr_data  input  DATA_W  write data.
- iss_en  input  1  issue strobe; marks iss_addr busy.
- iss_addr  input  ADDR_W  destination being issued.
- iss_err  output  1  one-cycle pulse: issue targeted an already-busy register.
- busy_vec  output  NUM_REGS  current scoreboard, bit i = register i busy.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers = 0, busy_vec = 0
  - rd_data1/2 = 0, rd_busy1/2 = 0, iss_err = 0
  - Reset asserted mid-operation discards pending writes and issues immediately.
  - Deassertion is sampled at the next rising clk.
- Write: at the rising edge with wr_en=1, mem[wr_addr] <= wr_data. All registers are writable; there is no hard-wired zero.
- Read:
  - At the rising edge with rd_en=1: rd_dataN <= mem[rd_addrN] and rd_busyN <= busy_vec[rd_addrN].
  - Latency is 1 cycle (data is visible the cycle after rd_en).
  - With rd_en=0, rd_dataN and rd_busyN hold their previous values.
  - Both ports may address the same register.
- Scoreboard (next state, per register i):
  - busy[i] <= (busy[i] & ~(wr_en & wr_addr==i)) | (iss_en & iss_addr==i).
  - Issue and write to the same register in the same cycle: set wins, register stays busy (a new producer is issued).
  - Writing a register that is not busy is legal; busy stays 0.
- iss_err:
  - Registered; equals iss_en & busy[iss_addr], using the pre-edge busy value.
  - A clear by a same-cycle write to iss_addr suppresses the error.
  - Cleared the next cycle unless re-triggered.
- busy_vec is a direct output of the scoreboard flops (no combinational path from inputs).
- Write/read same address, same edge: behaviour is defined by BYPASS_EN (see Optional Feature).
- No other simultaneous-event hazards exist.

Optional Feature:
- Macro: BANKED_REGFILE_BYPASS_EN.
- Defined:
  - rd_en, wr_en and rd_addrN==wr_addr on the same edge: rd_dataN captures wr_data (write-before-read).
  - rd_busyN captures the post-write busy value: 0, unless iss_en targets the same address on that edge.
- Undefined:
  - rd_dataN captures the old register contents.
  - rd_busyN captures the pre-edge busy bit.
  - The new value is readable from the following read onward.

Test Plan:
- Reset:
  - Drive rst low mid-run after writing R3=16'hBEEF and issuing R5.
  - -> Immediately, busy_vec=0 and rd_data1/2=0.
  - After release, read R3 -> 16'h0000.
- Write then read:
  - Write R7=16'h1234.
  - Next cycle rd_en with rd_addr1=7, rd_addr2=7 -> one cycle later rd_data1=rd_data2=16'h1234, rd_busy1/2=0.
- Scoreboard lifecycle:
  - iss_en R4 -> busy_vec[4]=1.
  - Read R4 -> rd_busy1=1.
  - Write R4=16'h00AA -> busy_vec[4]=0.
  - Read -> 16'h00AA, busy 0.
- Simultaneous issue/write/error:
  - R2 busy; same cycle iss_en R2 and wr_en R2 -> busy_vec[2] stays 1, iss_err=0.
  - Then iss_en R2 alone -> iss_err=1 for exactly one cycle.
- Bypass:
  - R9=16'h0001, busy.
  - Same edge: wr R9=16'hFFFF and rd R9.
  - With BYPASS_EN -> rd_data1=16'hFFFF, rd_busy1=0.
  - Without BYPASS_EN -> rd_data1=16'h0001, rd_busy1=1.
- Parametrisation:
  - DATA_W=32, ADDR_W=5.
  - Write R31=32'hDEADBEEF and R0=32'h1 -> reads return those values.
  - busy_vec width is 32.
